// File: rtl/shim_cfg_sync_pkg.sv
// Shared constants and FSM encoding
// for the config-domain sync bank.
package shim_cfg_sync_pkg;

  localparam int MODE_TRACK      = 0;
  localparam int MODE_LATCH_ONCE = 1;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_ACTIVE   = 2'd1,
    ST_FROZEN   = 2'd2
  } state_t;

endpackage

// File: rtl/shim_sync_stable.sv
// Multi-flop synchronizer with a
// consecutive-equal-sample stability detector.
module shim_sync_stable #(
  parameter int WIDTH        = 33,
  parameter int DEPTH        = 3,
  parameter int STABLE_COUNT = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             stable
);

  localparam int SC_W = $clog2(STABLE_COUNT + 1);
  localparam logic [SC_W-1:0] SC_MAX =
    SC_W'(STABLE_COUNT);

  logic [WIDTH-1:0] sync_q [DEPTH];
  logic [WIDTH-1:0] v_prev;
  logic [SC_W-1:0]  stab_cnt;
  logic             same;

  assign dout = sync_q[DEPTH-1];
  assign same = (dout == v_prev);

  // A saturated count alone would bless a
  // value that only just arrived at the tap.
  assign stable = same && (stab_cnt == SC_MAX);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++)
        sync_q[i] <= '0;
      v_prev   <= '0;
      stab_cnt <= '0;
    end else begin
      sync_q[0] <= din;
      for (int i = 1; i < DEPTH; i++)
        sync_q[i] <= sync_q[i-1];
      v_prev <= dout;
      if (!same)
        stab_cnt <= '0;
      else if (stab_cnt != SC_MAX)
        stab_cnt <= stab_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/shim_cfg_sync_bank.sv
// Config bus crossing bank: sync, stability
// window, hold gating, latch-once, timeout.
module shim_cfg_sync_bank
  import shim_cfg_sync_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 3,
  parameter int STABLE_COUNT = 2,
  parameter int MODE         = 0,
  parameter int TIMEOUT_CYC  = 1024,
  parameter int CNT_W        = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [DATA_W-1:0] din,
  input  logic              en_in,
  input  logic              hold,
  output logic [DATA_W-1:0] dout,
  output logic              en_out,
  output logic              update,
  output logic              changed,
  output logic              unstable_err,
  output logic [CNT_W-1:0]  commit_count
);

  localparam int W    = DATA_W + 1;
  localparam int TO_W = $clog2(TIMEOUT_CYC + 2);
  localparam logic [TO_W-1:0] TO_MAX =
    TO_W'(TIMEOUT_CYC);

  logic [W-1:0]      v_s;
  logic              stable;
  logic              en_s;
  logic [DATA_W-1:0] d_s;
  logic              can;
  logic              commit;
  logic [TO_W-1:0]   to_cnt;
  state_t            state_q;
  state_t            state_d;

  shim_sync_stable #(
    .WIDTH        (W),
    .DEPTH        (DEPTH),
    .STABLE_COUNT (STABLE_COUNT)
  ) u_sync (
    .clk    (clk),
    .resetn (resetn),
    .din    ({en_in, din}),
    .dout   (v_s),
    .stable (stable)
  );

  assign en_s = v_s[DATA_W];
  assign d_s  = v_s[DATA_W-1:0];
  // en_s=0 forces can=0, so disable beats commit.
  assign can  = stable && en_s && !hold;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      state_q <= ST_DISABLED;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!en_s) begin
      state_d = ST_DISABLED;
    end else begin
      unique case (state_q)
        ST_DISABLED:
          if (can)
            state_d = (MODE == MODE_LATCH_ONCE) ?
                      ST_FROZEN : ST_ACTIVE;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    commit = 1'b0;
    unique case (state_q)
      ST_DISABLED: commit = can;
      ST_ACTIVE:
        commit = can && (v_s != {en_out, dout});
      default: commit = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dout         <= '0;
      en_out       <= 1'b0;
      update       <= 1'b0;
      changed      <= 1'b0;
      commit_count <= '0;
    end else begin
      update  <= commit;
      changed <= commit && (d_s != dout);
      if (!en_s)
        en_out <= 1'b0;
      else if (commit)
        en_out <= 1'b1;
      if (commit) begin
        dout         <= d_s;
        commit_count <= commit_count + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      to_cnt       <= '0;
      unstable_err <= 1'b0;
    end else if (!en_s) begin
      to_cnt       <= '0;
      unstable_err <= 1'b0;
    end else begin
      if (stable)
        to_cnt <= '0;
      else if (to_cnt != TO_MAX)
        to_cnt <= to_cnt + 1'b1;
      if (TIMEOUT_CYC != 0 && to_cnt == TO_MAX)
        unstable_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_shim_cfg_sync_bank.sv
// Scoreboard bench: TRACK instance (short
// timeout, 2-bit count) and LATCH_ONCE instance.
module tb_shim_cfg_sync_bank;

  typedef struct {
    logic [31:0] dout;
    logic        chg;
    logic [7:0]  cnt;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  logic [31:0] d0 = '0;
  logic        en0 = 1'b0;
  logic        hold0 = 1'b0;
  logic [31:0] q0_dout;
  logic        q0_en, q0_upd, q0_chg, q0_err;
  logic [1:0]  q0_cnt;

  logic [31:0] d1 = '0;
  logic        en1 = 1'b0;
  logic        hold1 = 1'b0;
  logic [31:0] q1_dout;
  logic        q1_en, q1_upd, q1_chg, q1_err;
  logic [7:0]  q1_cnt;

  exp_t        sb0[$];
  exp_t        sb1[$];
  logic [31:0] m0_dout = '0;
  logic [1:0]  m0_cnt = '0;
  logic [31:0] m1_dout = '0;
  logic [7:0]  m1_cnt = '0;
  int          t0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  shim_cfg_sync_bank #(
    .MODE(0), .TIMEOUT_CYC(8), .CNT_W(2)
  ) u0 (
    .clk(clk), .resetn(resetn),
    .din(d0), .en_in(en0), .hold(hold0),
    .dout(q0_dout), .en_out(q0_en),
    .update(q0_upd), .changed(q0_chg),
    .unstable_err(q0_err),
    .commit_count(q0_cnt)
  );

  shim_cfg_sync_bank #(
    .MODE(1)
  ) u1 (
    .clk(clk), .resetn(resetn),
    .din(d1), .en_in(en1), .hold(hold1),
    .dout(q1_dout), .en_out(q1_en),
    .update(q1_upd), .changed(q1_chg),
    .unstable_err(q1_err),
    .commit_count(q1_cnt)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push0(input logic [31:0] d,
                       input int at);
    exp_t e;
    m0_cnt = m0_cnt + 1'b1;
    e.dout = d;
    e.chg  = (d != m0_dout);
    e.cnt  = {6'd0, m0_cnt};
    e.cyc  = at;
    m0_dout = d;
    sb0.push_back(e);
  endtask

  task automatic push1(input logic [31:0] d,
                       input int at);
    exp_t e;
    m1_cnt = m1_cnt + 1'b1;
    e.dout = d;
    e.chg  = (d != m1_dout);
    e.cnt  = m1_cnt;
    e.cyc  = at;
    m1_dout = d;
    sb1.push_back(e);
  endtask

  always @(negedge clk) begin
    if (resetn && q0_upd) begin
      exp_t e;
      chk("u0_expected_update", 64'(sb0.size() != 0), 64'd1);
      if (sb0.size() != 0) begin
        e = sb0.pop_front();
        chk("u0_dout", 64'(q0_dout), 64'(e.dout));
        chk("u0_en_out", 64'(q0_en), 64'd1);
        chk("u0_changed", 64'(q0_chg), 64'(e.chg));
        chk("u0_count", 64'(q0_cnt), 64'(e.cnt));
        chk("u0_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (resetn && q1_upd) begin
      exp_t e;
      chk("u1_expected_update", 64'(sb1.size() != 0), 64'd1);
      if (sb1.size() != 0) begin
        e = sb1.pop_front();
        chk("u1_dout", 64'(q1_dout), 64'(e.dout));
        chk("u1_en_out", 64'(q1_en), 64'd1);
        chk("u1_changed", 64'(q1_chg), 64'(e.chg));
        chk("u1_count", 64'(q1_cnt), 64'(e.cnt));
        chk("u1_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  initial begin
    #22;
    chk("rst_dout", 64'(q0_dout), 64'd0);
    chk("rst_en_out", 64'(q0_en), 64'd0);
    chk("rst_update", 64'(q0_upd), 64'd0);
    chk("rst_changed", 64'(q0_chg), 64'd0);
    chk("rst_err", 64'(q0_err), 64'd0);
    chk("rst_count", 64'(q0_cnt), 64'd0);
    chk("rst_u1_dout", 64'(q1_dout), 64'd0);
    step(1);
    resetn = 1'b1;
    step(5);

    // basic commit
    d0 = 32'hA5A5_0001;
    en0 = 1'b1;
    push0(d0, cyc + 7);
    step(10);
    chk("basic_dout", 64'(q0_dout), 64'hA5A5_0001);
    chk("basic_err", 64'(q0_err), 64'd0);

    // glitching bus and timeout
    t0 = cyc;
    for (int i = 0; i < 20; i++) begin
      d0 = (i % 2 == 1) ? 32'h2 : 32'h1;
      if (i == 11)
        chk("glitch_err_pre", 64'(q0_err), 64'd0);
      if (i == 12)
        chk("glitch_err_set", 64'(q0_err), 64'd1);
      step(1);
    end
    chk("glitch_no_commit", 64'(q0_dout), 64'hA5A5_0001);
    d0 = 32'h3;
    push0(d0, cyc + 7);
    step(10);
    chk("glitch_dout", 64'(q0_dout), 64'h3);
    chk("glitch_err_sticky", 64'(q0_err), 64'd1);

    // hold gating
    hold0 = 1'b1;
    d0 = 32'h55;
    step(12);
    chk("hold_blocks", 64'(q0_dout), 64'h3);
    hold0 = 1'b0;
    push0(32'h55, cyc + 1);
    step(3);
    hold0 = 1'b1;
    d0 = 32'h66;
    step(12);
    chk("hold_keeps", 64'(q0_dout), 64'h55);
    hold0 = 1'b0;
    push0(32'h66, cyc + 1);
    step(3);

    // immediate disable
    d0 = 32'h10;
    push0(d0, cyc + 7);
    step(10);
    en0 = 1'b0;
    step(3);
    chk("dis_en_pre", 64'(q0_en), 64'd1);
    chk("dis_err_pre", 64'(q0_err), 64'd1);
    step(1);
    chk("dis_en_out", 64'(q0_en), 64'd0);
    chk("dis_err_clr", 64'(q0_err), 64'd0);
    chk("dis_dout", 64'(q0_dout), 64'h10);
    step(6);

    // re-enable same data, redundancy, wrap
    en0 = 1'b1;
    push0(32'h10, cyc + 7);
    step(10);
    d0 = 32'h11;
    push0(d0, cyc + 7);
    step(10);
    d0 = 32'h12;
    step(1);
    d0 = 32'h11;
    step(12);
    chk("redund_dout", 64'(q0_dout), 64'h11);
    chk("redund_count", 64'(q0_cnt), 64'(m0_cnt));
    for (int k = 0; k < 3; k++) begin
      d0 = 32'h20 + 32'(k);
      push0(d0, cyc + 7);
      step(10);
    end
    chk("wrap_count", 64'(q0_cnt), 64'd2);

    // latch-once instance
    en1 = 1'b1;
    d1 = 32'h7;
    push1(d1, cyc + 7);
    step(10);
    d1 = 32'h9;
    step(50);
    chk("latch_frozen", 64'(q1_dout), 64'h7);
    chk("latch_en", 64'(q1_en), 64'd1);
    en1 = 1'b0;
    step(8);
    chk("latch_dis", 64'(q1_en), 64'd0);
    en1 = 1'b1;
    push1(32'h9, cyc + 7);
    step(10);
    chk("latch_dout2", 64'(q1_dout), 64'h9);
    chk("latch_count", 64'(q1_cnt), 64'd2);

    step(5);
    chk("u0_sb_drained", 64'(sb0.size()), 64'd0);
    chk("u1_sb_drained", 64'(sb1.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
